collect_tracker: RTL and testbench

//  Owns the collectible-item bitmap for the maze grid, on the write side of the

---
 rtl/collect_tracker.sv | 216 +++++++++++++++++++++
 tb/tb_collect_tracker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collect_tracker.sv
// collect_tracker: collectible-item bitmap for the maze grid.
//
// Game logic places/removes items (load) and removes them as the player walks over them
// (collect). The grid scan counter presents one cell per cycle on index_x/index_y and
// flags end-of-round on next_round; each complete round yields an "all collected"
// verdict. A live count of set bits is kept for HUD/score logic.
//
// Optional feature: define COLLECT_CHECK_EN to enable a sticky bitmap/count consistency
// check evaluated at every clean verdict; otherwise consistency_err_o is tied to 0.
//
// Ports:
//   clk_i, rst_i                    clock (rising edge), asynchronous active-high reset
//   clear_i                         erase all items and restart round tracking
//   load_en_i, load_x_i, load_y_i,
//   load_item_i                     write item bit (1 place, 0 remove)
//   collect_en_i, player_x_i,
//   player_y_i                      player occupies this cell this cycle
//   index_x_i, index_y_i,
//   next_round_i                    scan counter position and end-of-round flag
//   item_here_o                     item bit at scan index, one cycle later
//   got_item_o                      pulse: a collect removed an item
//   items_left_o                    number of set item bits
//   all_collected_o                 verdict of the last complete scan round
//   round_done_o                    pulse when all_collected_o updates
//   consistency_err_o               sticky check flag (COLLECT_CHECK_EN only)
module collect_tracker #(
  parameter int unsigned SIZE_X = 40,
  parameter int unsigned SIZE_Y = 20,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned CNT_W  = $clog2(SIZE_X * SIZE_Y + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_en_i,
  input  logic [IDX_W-1:0] load_x_i,
  input  logic [IDX_W-1:0] load_y_i,
  input  logic             load_item_i,
  input  logic             collect_en_i,
  input  logic [IDX_W-1:0] player_x_i,
  input  logic [IDX_W-1:0] player_y_i,
  input  logic [IDX_W-1:0] index_x_i,
  input  logic [IDX_W-1:0] index_y_i,
  input  logic             next_round_i,
  output logic             item_here_o,
  output logic             got_item_o,
  output logic [CNT_W-1:0] items_left_o,
  output logic             all_collected_o,
  output logic             round_done_o,
  output logic             consistency_err_o
);

  localparam int unsigned XW = (SIZE_X > 1) ? $clog2(SIZE_X) : 1;
  localparam int unsigned YW = (SIZE_Y > 1) ? $clog2(SIZE_Y) : 1;
  localparam logic [IDX_W:0] XLim = (IDX_W + 1)'(SIZE_X);
  localparam logic [IDX_W:0] YLim = (IDX_W + 1)'(SIZE_Y);

  typedef enum logic [0:0] {StWaitRound, StAccum} state_e;

  function automatic logic in_grid(input logic [IDX_W-1:0] x, input logic [IDX_W-1:0] y);
    return ({1'b0, x} < XLim) && ({1'b0, y} < YLim);
  endfunction

  logic [SIZE_Y-1:0][SIZE_X-1:0] bitmap_q, bitmap_d;
  logic [CNT_W-1:0]              items_q, items_d;
  logic                          got_q, got_d;
  logic                          item_here_q, item_here_d;
  logic                          any_seen_q, any_seen_d;
  logic                          all_col_q, all_col_d;
  logic                          round_done_q, round_done_d;
  logic                          next_round_q;
  state_e                        state_q, state_d;

  logic [XW-1:0] lx, px, ix;
  logic [YW-1:0] ly, py, iy;
  logic          load_ok, player_ok, index_ok;
  logic          load_old, player_bit, index_bit;
  logic          round_rise;

  assign lx = load_x_i[XW-1:0];
  assign ly = load_y_i[YW-1:0];
  assign px = player_x_i[XW-1:0];
  assign py = player_y_i[YW-1:0];
  assign ix = index_x_i[XW-1:0];
  assign iy = index_y_i[YW-1:0];

  assign load_ok   = in_grid(load_x_i, load_y_i);
  assign player_ok = in_grid(player_x_i, player_y_i);
  assign index_ok  = in_grid(index_x_i, index_y_i);

  // Out-of-range cells read as empty, so they never count or get written.
  assign load_old   = load_ok   ? bitmap_q[ly][lx] : 1'b0;
  assign player_bit = player_ok ? bitmap_q[py][px] : 1'b0;
  assign index_bit  = index_ok  ? bitmap_q[iy][ix] : 1'b0;

  // A held next_round only counts once.
  assign round_rise = next_round_i & ~next_round_q;

  // Bitmap writes: clear > load > collect. Only bit changes move the count, so it can
  // neither overflow nor underflow.
  always_comb begin
    bitmap_d = bitmap_q;
    items_d  = items_q;
    got_d    = 1'b0;
    if (clear_i) begin
      bitmap_d = '0;
      items_d  = '0;
    end else if (load_en_i) begin
      if (load_ok && (load_old != load_item_i)) begin
        bitmap_d[ly][lx] = load_item_i;
        items_d          = load_item_i ? items_q + CNT_W'(1) : items_q - CNT_W'(1);
      end
    end else if (collect_en_i && player_bit) begin
      bitmap_d[py][px] = 1'b0;
      items_d          = items_q - CNT_W'(1);
      got_d            = 1'b1;
    end
  end

  assign item_here_d = index_bit;

  // Round tracking. The first round after reset/clear is partial, so it only arms ACCUM.
  always_comb begin
    state_d      = state_q;
    any_seen_d   = any_seen_q;
    all_col_d    = all_col_q;
    round_done_d = 1'b0;
    if (clear_i) begin
      state_d    = StWaitRound;
      any_seen_d = 1'b0;
    end else begin
      if (!next_round_i) begin
        any_seen_d = any_seen_q | index_bit;
      end
      if (round_rise) begin
        any_seen_d = 1'b0;
        unique case (state_q)
          StWaitRound: state_d = StAccum;
          StAccum: begin
            all_col_d    = ~any_seen_q;
            round_done_d = 1'b1;
          end
          default: state_d = StWaitRound;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bitmap_q     <= '0;
      items_q      <= '0;
      got_q        <= 1'b0;
      item_here_q  <= 1'b0;
      any_seen_q   <= 1'b0;
      all_col_q    <= 1'b0;
      round_done_q <= 1'b0;
      next_round_q <= 1'b0;
      state_q      <= StWaitRound;
    end else begin
      bitmap_q     <= bitmap_d;
      items_q      <= items_d;
      got_q        <= got_d;
      item_here_q  <= item_here_d;
      any_seen_q   <= any_seen_d;
      all_col_q    <= all_col_d;
      round_done_q <= round_done_d;
      next_round_q <= next_round_i;
      state_q      <= state_d;
    end
  end

`ifdef COLLECT_CHECK_EN
  // A round without writes must see items exactly when the count is non-zero.
  logic dirty_q, dirty_d;
  logic err_q, err_d;
  logic write_eff;

  assign write_eff = ~clear_i & (items_d != items_q);

  always_comb begin
    dirty_d = dirty_q | write_eff;
    err_d   = err_q;
    if (clear_i) begin
      dirty_d = 1'b0;
      err_d   = 1'b0;
    end else if (round_rise) begin
      dirty_d = 1'b0;
      if ((state_q == StAccum) && !dirty_q && ((items_q == '0) == any_seen_q)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dirty_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dirty_q <= dirty_d;
      err_q   <= err_d;
    end
  end

  assign consistency_err_o = err_q;
`else
  assign consistency_err_o = 1'b0;
`endif

  assign item_here_o     = item_here_q;
  assign got_item_o      = got_q;
  assign items_left_o    = items_q;
  assign all_collected_o = all_col_q;
  assign round_done_o    = round_done_q;

endmodule

// File: tb/tb_collect_tracker.sv
// Self-checking bench for collect_tracker: randomized and directed stimulus, a
// reference model of the item grid kept as a plain 2-D array, and a scoreboard whose
// expected per-cycle outputs are checked by an independent monitor process.
module tb_collect_tracker;

  localparam int SX = 40;
  localparam int SY = 20;

  logic       clk = 1'b0;
  logic       rst, clear, load_en, load_item, collect_en, next_round;
  logic [5:0] load_x, load_y, player_x, player_y, index_x, index_y;
  logic       item_here, got_item, all_collected, round_done, consistency_err;
  logic [9:0] items_left;

  always #5 clk = ~clk;

  collect_tracker dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .clear_i          (clear),
    .load_en_i        (load_en),
    .load_x_i         (load_x),
    .load_y_i         (load_y),
    .load_item_i      (load_item),
    .collect_en_i     (collect_en),
    .player_x_i       (player_x),
    .player_y_i       (player_y),
    .index_x_i        (index_x),
    .index_y_i        (index_y),
    .next_round_i     (next_round),
    .item_here_o      (item_here),
    .got_item_o       (got_item),
    .items_left_o     (items_left),
    .all_collected_o  (all_collected),
    .round_done_o     (round_done),
    .consistency_err_o(consistency_err)
  );

  typedef struct {
    bit rst, clr, le, li, ce, nr;
    int lx, ly, px, py, ix, iy;
  } stim_t;

  typedef struct {
    bit ih, got, rd, ac, err;
    int left;
  } exp_t;

  stim_t s;
  exp_t  exp_q[$];
  bit    sb_en = 1'b1;
  int    n_pass = 0;
  int    n_total = 0;

  // Reference model: the grid as an array, verdict state and round arming.
  bit m_bm[SY][SX];
  bit m_wait = 1'b1;
  bit m_prev_nr = 1'b0;
  bit m_verdict = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
  endtask

  function automatic bit in_grid(input int x, input int y);
    return (x < SX) && (y < SY);
  endfunction

  function automatic int total();
    int n = 0;
    for (int y = 0; y < SY; y++)
      for (int x = 0; x < SX; x++) n += int'(m_bm[y][x]);
    return n;
  endfunction

  task automatic clr_bm();
    for (int y = 0; y < SY; y++)
      for (int x = 0; x < SX; x++) m_bm[y][x] = 1'b0;
  endtask

  // Expected outputs after the coming clock edge. Verdict = "grid empty" because the
  // bench always scans the whole grid after the last write of a round.
  task automatic model_step();
    exp_t e;
    bit   rise;
    e = '{default: 0};
    if (s.rst) begin
      clr_bm();
      m_wait    = 1'b1;
      m_prev_nr = 1'b0;
      m_verdict = 1'b0;
    end else begin
      if (in_grid(s.ix, s.iy)) e.ih = m_bm[s.iy][s.ix];
      rise      = s.nr && !m_prev_nr;
      m_prev_nr = s.nr;
      if (s.clr) begin
        clr_bm();
        m_wait = 1'b1;
      end else begin
        if (s.le) begin
          if (in_grid(s.lx, s.ly)) m_bm[s.ly][s.lx] = s.li;
        end else if (s.ce && in_grid(s.px, s.py)) begin
          if (m_bm[s.py][s.px]) begin
            m_bm[s.py][s.px] = 1'b0;
            e.got = 1'b1;
          end
        end
        if (rise) begin
          if (m_wait) m_wait = 1'b0;
          else begin
            m_verdict = (total() == 0);
            e.rd      = 1'b1;
          end
        end
      end
    end
    e.ac   = m_verdict;
    e.left = total();
    if (sb_en) exp_q.push_back(e);
  endtask

  task automatic idle();
    s = '{default: 0};
    s.ix = 63;
    s.iy = 63;
  endtask

  task automatic tick();
    @(negedge clk);
    rst        = s.rst;
    clear      = s.clr;
    load_en    = s.le;
    load_x     = 6'(s.lx);
    load_y     = 6'(s.ly);
    load_item  = s.li;
    collect_en = s.ce;
    player_x   = 6'(s.px);
    player_y   = 6'(s.py);
    index_x    = 6'(s.ix);
    index_y    = 6'(s.iy);
    next_round = s.nr;
    model_step();
  endtask

  task automatic do_load(input int x, input int y, input bit item);
    idle(); s.le = 1'b1; s.lx = x; s.ly = y; s.li = item; tick();
  endtask

  task automatic do_collect(input int x, input int y);
    idle(); s.ce = 1'b1; s.px = x; s.py = y; tick();
  endtask

  task automatic do_clear();
    idle(); s.clr = 1'b1; tick();
  endtask

  task automatic scan_rows(input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = 0; x < SX; x++) begin
        idle(); s.ix = x; s.iy = y; tick();
      end
  endtask

  task automatic end_round(input int hold);
    for (int k = 0; k < hold; k++) begin
      idle(); s.nr = 1'b1; tick();
    end
    idle(); tick();
  endtask

  task automatic scan_round(input int hold);
    scan_rows(0, SY - 1);
    end_round(hold);
  endtask

  // Monitor: compares every presented output cycle against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("item_here", int'(item_here), int'(e.ih));
      chk("got_item", int'(got_item), int'(e.got));
      chk("round_done", int'(round_done), int'(e.rd));
      chk("all_collected", int'(all_collected), int'(e.ac));
      chk("items_left", int'(items_left), e.left);
      chk("consistency_err", int'(consistency_err), int'(e.err));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    s.rst = 1'b1;
    tick(); tick();
    idle(); tick();

    // Empty grid: first round arms, second gives all_collected=1.
    scan_round(1);
    scan_round(2);

    // Two items, including the far corner.
    do_load(5, 3, 1'b1);
    do_load(39, 19, 1'b1);
    do_load(5, 3, 1'b1);
    scan_round(1);

    // Collect, repeat collect, last item.
    do_collect(5, 3);
    do_collect(5, 3);
    do_collect(39, 19);
    scan_round(3);

    // Load wins over a same-cycle collect; out-of-range load ignored.
    idle();
    s.le = 1'b1; s.lx = 7; s.ly = 7; s.li = 1'b1;
    s.ce = 1'b1; s.px = 7; s.py = 7;
    tick();
    do_load(63, 0, 1'b1);
    do_collect(63, 63);
    scan_round(1);
    do_load(7, 7, 1'b0);
    scan_round(1);

    // Clear mid-round: next boundary only re-arms, the following one has a verdict.
    do_load(1, 1, 1'b1);
    do_load(2, 2, 1'b1);
    scan_rows(0, 9);
    do_clear();
    scan_rows(10, SY - 1);
    end_round(1);
    scan_round(1);

    // Randomized write phases, each followed by a full scan round.
    for (int it = 0; it < 14; it++) begin
      int n = $urandom_range(5, 30);
      for (int c = 0; c < n; c++) begin
        int op = $urandom_range(0, 99);
        idle();
        if (op < 35 || (op >= 80 && op < 90)) begin
          s.le = 1'b1;
          s.li = 1'($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 3) == 0) begin
            s.lx = $urandom_range(0, 63); s.ly = $urandom_range(0, 63);
          end else begin
            s.lx = $urandom_range(0, 5); s.ly = $urandom_range(0, 3);
          end
        end
        if (op >= 35 && op < 90) begin
          s.ce = 1'b1;
          s.px = $urandom_range(0, 5); s.py = $urandom_range(0, 3);
        end
        if (op == 97) s.clr = 1'b1;
        if (op == 98) s.rst = 1'b1;
        tick();
      end
      scan_round($urandom_range(1, 3));
    end

`ifdef COLLECT_CHECK_EN
    // Count forced out of step with an empty bitmap over a clean round.
    do_clear();
    scan_round(1);
    sb_en = 1'b0;
    @(posedge clk); #2;
    force dut.items_q = 10'd5;
    scan_round(1);
    chk("cons_err_set", int'(consistency_err), 1);
    release dut.items_q;
    idle(); tick(); tick(); tick();
    @(posedge clk); #2;
    chk("cons_err_sticky", int'(consistency_err), 1);
    do_clear();
    @(posedge clk); #2;
    chk("cons_err_cleared", int'(consistency_err), 0);
    sb_en = 1'b1;
`endif

    idle(); tick(); tick();
    @(posedge clk); #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
